// File: rtl/instr_word_pkg.sv
// ---------------------------------------------------------------------------
// instr_word_pkg
// Shared constants and helpers for the instruction word queue.
//   NOP_OPC      : opcode value carried by the default (empty) word
//   default_word : builds the default word {NOP_OPC, 0, 0} for a given
//                  opcode/operand width, right-aligned in a wide vector
// ---------------------------------------------------------------------------
package instr_word_pkg;

  localparam logic [15:0] NOP_OPC = 16'h0000;

  // Upper bound on a word's width; callers slice the low bits they need.
  localparam int MAX_WORD_W = 1024;

  // The opcode field sits above the two operands. The mask keeps exactly
  // opc_w opcode bits, so NOP_OPC is truncated for narrow opcodes and
  // zero-extended for wide ones.
  function automatic logic [MAX_WORD_W-1:0] default_word(input int opc_w, input int data_w);
    logic [MAX_WORD_W-1:0] opc_mask;
    opc_mask = ((MAX_WORD_W'(1) << opc_w) - MAX_WORD_W'(1)) << (2 * data_w);
    return (MAX_WORD_W'(NOP_OPC) << (2 * data_w)) & opc_mask;
  endfunction

endpackage

// File: rtl/instr_word_ptr.sv
// ---------------------------------------------------------------------------
// instr_word_ptr
// Queue slot pointer that wraps at DEPTH, which need not be a power of 2.
//   clock  : rising-edge clock
//   resetN : synchronous active-low reset, pointer -> 0
//   clr    : synchronous clear, pointer -> 0 (takes priority over inc)
//   inc    : advance the pointer by one slot, wrapping DEPTH-1 -> 0
//   ptr    : current slot index
// ---------------------------------------------------------------------------
module instr_word_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Explicit compare against DEPTH-1 so non-power-of-2 depths wrap correctly.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_word_queue.sv
// ---------------------------------------------------------------------------
// instr_word_queue
// FIFO of instruction words {opcode, i1, i0} between fetch and decode.
//   clock       : rising-edge clock
//   resetN      : synchronous active-low reset; all slots -> default word
//   flush       : synchronous clear of occupancy and pointers
//   in_valid    : producer offers in_word
//   in_ready    : queue has a free slot
//   in_word     : packed {opcode, i1, i0}
//   out_valid   : head entry is valid
//   out_ready   : consumer takes the head entry
//   out_word    : head entry, or the default word when empty
//   count       : current occupancy
//   almost_full : count >= AF_TH
// ---------------------------------------------------------------------------
module instr_word_queue
  import instr_word_pkg::*;
#(
  parameter int OPC_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = 3
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*DATA_W+OPC_W-1:0]  in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*DATA_W+OPC_W-1:0]  out_word,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int WORD_W = 2 * DATA_W + OPC_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] i1;
    logic [DATA_W-1:0] i0;
  } word_t;

  localparam logic [MAX_WORD_W-1:0] DEFAULT_FULL = default_word(OPC_W, DATA_W);
  localparam word_t DEFAULT_WORD = word_t'(DEFAULT_FULL[WORD_W-1:0]);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake flags decode registered occupancy only, so a full queue
  // refuses a push even in a cycle where the head is being popped.
  assign in_ready    = (count < CNT_W'(DEPTH));
  assign out_valid   = (count != '0);
  assign almost_full = (count >= CNT_W'(AF_TH));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_word = out_valid ? mem[rd_ptr] : DEFAULT_WORD;

  instr_word_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clock  (clock),
    .resetN (resetN),
    .clr    (flush),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  instr_word_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clock  (clock),
    .resetN (resetN),
    .clr    (flush),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  // Push is refused when full and pop when empty, so count stays in 0..DEPTH.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  // Popped slots are scrubbed back to the default word; the push is written
  // afterwards so it wins when it targets the slot being popped. A flush
  // leaves slot contents alone and drops any same-cycle push.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DEFAULT_WORD;
      end
    end else if (!flush) begin
      if (pop) begin
        mem[rd_ptr] <= DEFAULT_WORD;
      end
      if (push) begin
        mem[wr_ptr] <= word_t'(in_word);
      end
    end
  end

endmodule

// File: tb/tb_instr_word_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_word_queue
// Self-checking bench for instr_word_queue. Two instances share clock and
// reset: dut_a uses the default DEPTH=4/AF_TH=3, dut_b uses DEPTH=3/AF_TH=2.
// Each instance is shadowed by a plain queue model.
// ---------------------------------------------------------------------------
module tb_instr_word_queue;

  typedef struct packed {
    logic [15:0] opcode;
    logic [31:0] i1;
    logic [31:0] i0;
  } word_t;

  localparam word_t DEFAULT_WORD = '{opcode: 16'h0000, i1: 32'h0, i0: 32'h0};

  logic  clock;
  logic  resetN;

  logic  flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, almost_full_a;
  word_t in_word_a, out_word_a;
  logic [2:0] count_a;

  logic  flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, almost_full_b;
  word_t in_word_b, out_word_b;
  logic [1:0] count_b;

  int compared   = 0;
  int mismatched = 0;

  word_t qa[$];
  word_t qb[$];

  instr_word_queue #(.OPC_W(16), .DATA_W(32), .DEPTH(4), .AF_TH(3)) dut_a (
    .clock       (clock),
    .resetN      (resetN),
    .flush       (flush_a),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .in_word     (in_word_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .out_word    (out_word_a),
    .count       (count_a),
    .almost_full (almost_full_a)
  );

  instr_word_queue #(.OPC_W(16), .DATA_W(32), .DEPTH(3), .AF_TH(2)) dut_b (
    .clock       (clock),
    .resetN      (resetN),
    .flush       (flush_b),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .in_word     (in_word_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .out_word    (out_word_b),
    .count       (count_b),
    .almost_full (almost_full_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic word_t rand_word(input logic [15:0] opc);
    word_t w;
    w.opcode = opc;
    w.i1     = $urandom;
    w.i0     = $urandom;
    return w;
  endfunction

  function automatic word_t head_a();
    return (qa.size() != 0) ? qa[0] : DEFAULT_WORD;
  endfunction

  function automatic word_t head_b();
    return (qb.size() != 0) ? qb[0] : DEFAULT_WORD;
  endfunction

  // Drive one cycle into dut_a from a negedge, advance the model to match the
  // following posedge, and return at the next negedge with inputs idle.
  task automatic tick_a(input logic iv, input word_t iw, input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    in_valid_a  = iv;
    in_word_a   = iw;
    out_ready_a = ordy;
    flush_a     = fl;
    if (!resetN || fl) begin
      qa.delete();
    end else begin
      do_push = iv && (qa.size() < 4);
      do_pop  = ordy && (qa.size() > 0);
      if (do_pop) void'(qa.pop_front());
      if (do_push) qa.push_back(iw);
    end
    @(negedge clock);
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    flush_a     = 1'b0;
  endtask

  task automatic tick_b(input logic iv, input word_t iw, input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    in_valid_b  = iv;
    in_word_b   = iw;
    out_ready_b = ordy;
    flush_b     = fl;
    if (!resetN || fl) begin
      qb.delete();
    end else begin
      do_push = iv && (qb.size() < 3);
      do_pop  = ordy && (qb.size() > 0);
      if (do_pop) void'(qb.pop_front());
      if (do_push) qb.push_back(iw);
    end
    @(negedge clock);
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    flush_b     = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    qa.delete();
    qb.delete();
    compared++;
    if (count_a !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_count_a: got %0d expected 0", count_a);
    end
    compared++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || almost_full_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags_a: got v=%b r=%b af=%b expected v=0 r=1 af=0",
               out_valid_a, in_ready_a, almost_full_a);
    end
    compared++;
    if (out_word_a !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL reset_word_a: got %h expected %h", out_word_a, DEFAULT_WORD);
    end
    compared++;
    if (count_b !== 2'd0 || out_valid_b !== 1'b0 || in_ready_b !== 1'b1 ||
        out_word_b !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL reset_b: got c=%0d v=%b r=%b w=%h expected c=0 v=0 r=1 w=%h",
               count_b, out_valid_b, in_ready_b, out_word_b, DEFAULT_WORD);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 4; k++) begin
      tick_a(1'b1, rand_word(16'h0100 + 16'(k)), 1'b0, 1'b0);
      compared++;
      if (count_a !== 3'(k)) begin
        mismatched++;
        $display("[TB] FAIL fill_count: got %0d expected %0d", count_a, k);
      end
      compared++;
      if (almost_full_a !== (k >= 3) || in_ready_a !== (k < 4)) begin
        mismatched++;
        $display("[TB] FAIL fill_flags: got af=%b r=%b expected af=%b r=%b",
                 almost_full_a, in_ready_a, (k >= 3), (k < 4));
      end
    end
    tick_a(1'b1, rand_word(16'h0105), 1'b0, 1'b0);
    compared++;
    if (count_a !== 3'd4 || out_word_a.opcode !== 16'h0101) begin
      mismatched++;
      $display("[TB] FAIL fill_refuse: got c=%0d opc=%h expected c=4 opc=0101",
               count_a, out_word_a.opcode);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 4; k++) begin
      compared++;
      if (out_valid_a !== 1'b1 || out_word_a !== head_a() ||
          out_word_a.opcode !== 16'h0100 + 16'(k)) begin
        mismatched++;
        $display("[TB] FAIL drain_word: got v=%b w=%h expected v=1 w=%h",
                 out_valid_a, out_word_a, head_a());
      end
      tick_a(1'b0, DEFAULT_WORD, 1'b1, 1'b0);
    end
    compared++;
    if (out_valid_a !== 1'b0 || count_a !== 3'd0 || out_word_a !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL drain_empty: got v=%b c=%0d w=%h expected v=0 c=0 w=%h",
               out_valid_a, count_a, out_word_a, DEFAULT_WORD);
    end
  endtask

  task automatic test_stream_depth3();
    for (int k = 1; k <= 2; k++) begin
      tick_b(1'b1, rand_word(16'h0200 + 16'(k)), 1'b0, 1'b0);
    end
    for (int k = 1; k <= 10; k++) begin
      compared++;
      if (count_b !== 2'd2 || out_word_b !== head_b()) begin
        mismatched++;
        $display("[TB] FAIL stream_b: got c=%0d w=%h expected c=2 w=%h",
                 count_b, out_word_b, head_b());
      end
      tick_b(1'b1, rand_word(16'h0300 + 16'(k)), 1'b1, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (out_word_b !== head_b() || out_word_b.opcode !== 16'h0309 + 16'(k)) begin
        mismatched++;
        $display("[TB] FAIL stream_tail_b: got %h expected %h", out_word_b, head_b());
      end
      tick_b(1'b0, DEFAULT_WORD, 1'b1, 1'b0);
    end
    compared++;
    if (out_valid_b !== 1'b0 || count_b !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL stream_empty_b: got v=%b c=%0d expected v=0 c=0", out_valid_b, count_b);
    end
  endtask

  task automatic test_flush();
    word_t fresh;
    tick_a(1'b1, rand_word(16'h0A01), 1'b0, 1'b0);
    tick_a(1'b1, rand_word(16'h0A02), 1'b0, 1'b0);
    compared++;
    if (count_a !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL flush_pre: got %0d expected 2", count_a);
    end
    tick_a(1'b1, rand_word(16'hBAD0), 1'b0, 1'b1);
    compared++;
    if (count_a !== 3'd0 || out_valid_a !== 1'b0 || out_word_a !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL flush_clear: got c=%0d v=%b w=%h expected c=0 v=0 w=%h",
               count_a, out_valid_a, out_word_a, DEFAULT_WORD);
    end
    fresh = rand_word(16'h0401);
    tick_a(1'b1, fresh, 1'b0, 1'b0);
    compared++;
    if (count_a !== 3'd1 || out_word_a !== fresh) begin
      mismatched++;
      $display("[TB] FAIL flush_after: got c=%0d w=%h expected c=1 w=%h", count_a, out_word_a, fresh);
    end
    tick_a(1'b0, DEFAULT_WORD, 1'b1, 1'b0);
    compared++;
    if (count_a !== 3'd0 || out_word_a !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL flush_drain: got c=%0d w=%h expected c=0 w=%h",
               count_a, out_word_a, DEFAULT_WORD);
    end
  endtask

  task automatic test_reset_mid();
    word_t w;
    for (int k = 1; k <= 3; k++) begin
      tick_a(1'b1, rand_word(16'h0500 + 16'(k)), 1'b0, 1'b0);
    end
    compared++;
    if (count_a !== 3'd3 || almost_full_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_pre: got c=%0d af=%b expected c=3 af=1", count_a, almost_full_a);
    end
    resetN = 1'b0;
    tick_a(1'b1, rand_word(16'h0599), 1'b1, 1'b1);
    resetN = 1'b1;
    qb.delete();
    compared++;
    if (count_a !== 3'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1 ||
        almost_full_a !== 1'b0 || out_word_a !== DEFAULT_WORD) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got c=%0d v=%b r=%b af=%b w=%h expected c=0 v=0 r=1 af=0 w=%h",
               count_a, out_valid_a, in_ready_a, almost_full_a, out_word_a, DEFAULT_WORD);
    end
    w = rand_word(16'h0601);
    tick_a(1'b1, w, 1'b0, 1'b0);
    compared++;
    if (count_a !== 3'd1 || out_valid_a !== 1'b1 || out_word_a !== w) begin
      mismatched++;
      $display("[TB] FAIL mid_push: got c=%0d v=%b w=%h expected c=1 v=1 w=%h",
               count_a, out_valid_a, out_word_a, w);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      compared++;
      if (count_a !== 3'(qa.size()) || out_valid_a !== (qa.size() != 0) ||
          in_ready_a !== (qa.size() < 4) || almost_full_a !== (qa.size() >= 3)) begin
        mismatched++;
        $display("[TB] FAIL random_state cycle %0d: got c=%0d v=%b r=%b af=%b expected c=%0d",
                 n, count_a, out_valid_a, in_ready_a, almost_full_a, qa.size());
      end
      compared++;
      if (out_word_a !== head_a()) begin
        mismatched++;
        $display("[TB] FAIL random_word cycle %0d: got %h expected %h", n, out_word_a, head_a());
      end
      tick_a(1'($urandom_range(0, 1)), rand_word(16'($urandom)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    resetN      = 1'b0;
    flush_a     = 1'b0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    in_word_a   = DEFAULT_WORD;
    flush_b     = 1'b0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    in_word_b   = DEFAULT_WORD;
    @(negedge clock);

    test_reset();
    test_fill();
    test_drain();
    test_stream_depth3();
    test_flush();
    test_reset_mid();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
